// File: rtl/prim_reg_we_decode.sv
// Register write-enable decoder feeding the one-hot checker; escalates checker errors to sticky fatal.
// Optional: define REG_WE_FATAL_CLR_EN to allow clr_i to leave FATAL.
module prim_reg_we_decode #(
    parameter int NumRegs   = 32,
    parameter int AddrWidth = 8,
    parameter int CntWidth  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    output logic                 ready_o,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    output logic [NumRegs-1:0]   oh_o,
    output logic                 en_o,
    input  logic                 chk_err_i,
    output logic                 decode_err_o,
    output logic                 fatal_o,
    output logic [CntWidth-1:0]  wr_cnt_o,
    input  logic                 clr_i
);

    localparam int IdxW = AddrWidth - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FATAL = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [NumRegs-1:0]  oh_q, oh_d;
    logic                en_q, en_d;
    logic                derr_q, derr_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0]     idx;
    logic                addr_ok;
    logic                hs;
    logic                clr_ok;

    assign idx     = addr_i[AddrWidth-1:2];
    assign addr_ok = (addr_i[1:0] == 2'b00) &&
                     (32'(idx) < 32'(NumRegs));
    assign ready_o = (state_q == IDLE);
    assign hs      = req_i & ready_o;

`ifdef REG_WE_FATAL_CLR_EN
    // A fresh checker error wins over the clear
    assign clr_ok = clr_i & ~chk_err_i;
`else
    logic unused_clr;
    assign clr_ok     = 1'b0;
    assign unused_clr = clr_i;
`endif

    always_comb begin
        state_d = state_q;
        oh_d    = '0;
        en_d    = 1'b0;
        derr_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (chk_err_i) begin
                    state_d = FATAL;
                end else if (hs && we_i) begin
                    if (addr_ok) begin
                        state_d = WRITE;
                        oh_d    = NumRegs'(1) << idx;
                        en_d    = 1'b1;
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    end else begin
                        derr_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                state_d = chk_err_i ? FATAL : IDLE;
            end
            FATAL: begin
                if (clr_ok) state_d = IDLE;
            end
            default: begin
                state_d = FATAL;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            oh_q    <= '0;
            en_q    <= 1'b0;
            derr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            oh_q    <= oh_d;
            en_q    <= en_d;
            derr_q  <= derr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign oh_o         = oh_q;
    assign en_o         = en_q;
    assign decode_err_o = derr_q;
    assign fatal_o      = (state_q == FATAL);
    assign wr_cnt_o     = cnt_q;

endmodule
